mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a small register-file memory, with a clear sweep.
// Optional seven-segment decode of rdata is enabled by defining MEM_ARB_SEG_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [7:0]            SEG,
  output logic                  state_dbg
);

  // Handshake: a requester holds req (with we/addr/wdata stable) until it sees gnt in the
  // same cycle; the access happens at that edge. Reads answer one cycle later with rvalid.

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic                    last_b;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    gnt_any;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  assign state_dbg = state;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    busy      = 1'b0;
    case (state)
      RUN: begin
        if (clr) begin
          state_nxt = CLEAR;
        end else if (a_req && b_req) begin
          // tie goes to whoever was not served last
          a_gnt = last_b;
          b_gnt = ~last_b;
        end else begin
          a_gnt = a_req;
          b_gnt = b_req;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (&cnt) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign gnt_any   = a_gnt | b_gnt;
  assign sel_we    = a_gnt ? a_we    : b_we;
  assign sel_addr  = a_gnt ? a_addr  : b_addr;
  assign sel_wdata = a_gnt ? a_wdata : b_wdata;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      last_b <= 1'b1;
    end else begin
      // counter wraps back to zero as the sweep finishes
      if (state == CLEAR) cnt <= cnt + 1'b1;
      if (a_gnt)      last_b <= 1'b0;
      else if (b_gnt) last_b <= 1'b1;
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (gnt_any && sel_we) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      rdata    <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      if (gnt_any && !sel_we) rdata <= mem[sel_addr];
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

`ifdef MEM_ARB_SEG_EN
  logic [3:0] seg_nib;
  assign seg_nib = 4'(rdata);

  always_comb begin
    SEG = 8'h00;
    case (seg_nib)
      4'h0: SEG = 8'h3F;
      4'h1: SEG = 8'h06;
      4'h2: SEG = 8'h5B;
      4'h3: SEG = 8'h4F;
      4'h4: SEG = 8'h66;
      4'h5: SEG = 8'h6D;
      4'h6: SEG = 8'h7D;
      4'h7: SEG = 8'h07;
      4'h8: SEG = 8'h7F;
      4'h9: SEG = 8'h6F;
      4'hA: SEG = 8'h77;
      4'hB: SEG = 8'h7C;
      4'hC: SEG = 8'h39;
      4'hD: SEG = 8'h5E;
      4'hE: SEG = 8'h79;
      4'hF: SEG = 8'h71;
      default: SEG = 8'h00;
    endcase
  end
`else
  assign SEG = 8'h00;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter; hand-written sequence covers reset during a sweep.
module tb_mem_arbiter;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       clr;
  logic       a_req, a_we, b_req, b_we;
  logic [1:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, busy, state_dbg;
  logic [3:0] rdata;
  logic [7:0] SEG;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
    .clk_2(clk_2), .reset(reset), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .busy(busy), .SEG(SEG), .state_dbg(state_dbg)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic       clr, ar, aw;
    logic [1:0] aa;
    logic [3:0] ad;
    logic       br, bw;
    logic [1:0] ba;
    logic [3:0] bd;
    logic       eag, ebg, ebusy, earv, ebrv;
    logic [3:0] erd;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic c, ar, aw, input logic [1:0] aa, input logic [3:0] ad,
                              input logic br, bw, input logic [1:0] ba, input logic [3:0] bd,
                              input logic eag, ebg, ebusy, earv, ebrv, input logic [3:0] erd);
    vec_t v;
    v.clr = c;  v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br;  v.bw = bw; v.ba = ba; v.bd = bd;
    v.eag = eag; v.ebg = ebg; v.ebusy = ebusy; v.earv = earv; v.ebrv = ebrv; v.erd = erd;
    return v;
  endfunction

  function automatic logic [7:0] exp_seg(input logic [3:0] d);
`ifdef MEM_ARB_SEG_EN
    case (d)
      4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
      4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
      4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
      4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
    endcase
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, ar, aw, input logic [1:0] aa, input logic [3:0] ad,
                       input logic br, bw, input logic [1:0] ba, input logic [3:0] bd);
    clr = c; a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic next_cycle();
    @(posedge clk_2);
    #1;
  endtask

  initial begin
    // A read 2, A write 1=9, B read 1
    vecs[0]  = mk(0,1,0,2,0, 0,0,0,0, 1,0,0,0,0,4'h0);
    vecs[1]  = mk(0,1,1,1,9, 0,0,0,0, 1,0,0,1,0,4'h0);
    vecs[2]  = mk(0,0,0,0,0, 1,0,1,0, 0,1,0,0,0,4'h0);
    vecs[3]  = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,1,4'h9);
    // continuous tie: A, B, A, B
    vecs[4]  = mk(0,1,0,1,0, 1,0,0,0, 1,0,0,0,0,4'h9);
    vecs[5]  = mk(0,1,0,1,0, 1,0,0,0, 0,1,0,1,0,4'h9);
    vecs[6]  = mk(0,1,0,1,0, 1,0,0,0, 1,0,0,0,1,4'h0);
    vecs[7]  = mk(0,1,0,1,0, 1,0,0,0, 0,1,0,1,0,4'h9);
    // fill 5,6,7,8 then read word 3 so rdata is nonzero before the sweep
    vecs[8]  = mk(0,1,1,0,5, 0,0,0,0, 1,0,0,0,1,4'h0);
    vecs[9]  = mk(0,1,1,1,6, 0,0,0,0, 1,0,0,0,0,4'h0);
    vecs[10] = mk(0,1,1,2,7, 0,0,0,0, 1,0,0,0,0,4'h0);
    vecs[11] = mk(0,1,1,3,8, 0,0,0,0, 1,0,0,0,0,4'h0);
    vecs[12] = mk(0,0,0,0,0, 1,0,3,0, 0,1,0,0,0,4'h0);
    // clr with a_req, sweep with a second clr in the third sweep cycle
    vecs[13] = mk(1,1,0,0,0, 0,0,0,0, 0,0,0,0,1,4'h8);
    vecs[14] = mk(0,1,0,0,0, 0,0,0,0, 0,0,1,0,0,4'h8);
    vecs[15] = mk(0,1,0,0,0, 0,0,0,0, 0,0,1,0,0,4'h8);
    vecs[16] = mk(1,1,0,0,0, 0,0,0,0, 0,0,1,0,0,4'h8);
    vecs[17] = mk(0,1,0,0,0, 0,0,0,0, 0,0,1,0,0,4'h8);
    vecs[18] = mk(0,1,0,0,0, 0,0,0,0, 1,0,0,0,0,4'h8);
    vecs[19] = mk(0,1,0,1,0, 0,0,0,0, 1,0,0,1,0,4'h0);
    vecs[20] = mk(0,1,0,2,0, 0,0,0,0, 1,0,0,1,0,4'h0);
    vecs[21] = mk(0,1,0,3,0, 0,0,0,0, 1,0,0,1,0,4'h0);
    vecs[22] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,1,0,4'h0);

    reset = 1'b1;
    drive(0,0,0,0,0, 0,0,0,0);
    repeat (2) @(posedge clk_2);
    @(negedge clk_2);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_seg", SEG, exp_seg(4'h0));
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      next_cycle();
      drive(vecs[i].clr, vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad,
            vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      @(negedge clk_2);
      chk($sformatf("v%0d_a_gnt", i),    a_gnt,    vecs[i].eag);
      chk($sformatf("v%0d_b_gnt", i),    b_gnt,    vecs[i].ebg);
      chk($sformatf("v%0d_busy", i),     busy,     vecs[i].ebusy);
      chk($sformatf("v%0d_a_rvalid", i), a_rvalid, vecs[i].earv);
      chk($sformatf("v%0d_b_rvalid", i), b_rvalid, vecs[i].ebrv);
      chk($sformatf("v%0d_rdata", i),    rdata,    vecs[i].erd);
      chk($sformatf("v%0d_seg", i),      SEG,      exp_seg(vecs[i].erd));
      chk($sformatf("v%0d_one_gnt", i),  a_gnt & b_gnt, 0);
    end

    // reset asserted in the second sweep cycle, after writing C into word 2
    next_cycle();
    drive(0,1,1,2,4'hC, 0,0,0,0);
    @(negedge clk_2);
    chk("s5_wr_gnt", a_gnt, 1);
    next_cycle();
    drive(1,0,0,0,0, 0,0,0,0);
    @(negedge clk_2);
    chk("s5_clr_busy", busy, 0);
    next_cycle();
    drive(0,0,0,0,0, 0,0,0,0);
    @(negedge clk_2);
    chk("s5_sweep1_busy", busy, 1);
    next_cycle();
    chk("s5_sweep2_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_rdata", rdata, 0);
    chk("s5_rst_state", state_dbg, 0);
    @(negedge clk_2);
    reset = 1'b0;

    next_cycle();
    drive(0,1,0,2,0, 1,0,3,0);
    @(negedge clk_2);
    chk("s5_tie_a_gnt", a_gnt, 1);
    chk("s5_tie_b_gnt", b_gnt, 0);
    chk("s5_tie_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(0,1,0,2'(i),0, 0,0,0,0);
      @(negedge clk_2);
      chk($sformatf("s5_rd%0d_gnt", i), a_gnt, 1);
      chk($sformatf("s5_rd%0d_prev_rvalid", i), a_rvalid, 1);
      chk($sformatf("s5_rd%0d_prev_rdata", i), rdata, 0);
    end
    next_cycle();
    drive(0,0,0,0,0, 0,0,0,0);
    @(negedge clk_2);
    chk("s5_last_rvalid", a_rvalid, 1);
    chk("s5_last_rdata", rdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
